// File: rtl/ah_pl2ddr_buf_ctrl.sv
// ============================================================================
// ah_pl2ddr_buf_ctrl : ping-pong write scheduler for the PL-to-DDR buffer
// Revision: 1.0
// ============================================================================
`default_nettype none

module ah_pl2ddr_buf_ctrl #(
    parameter int ADDR_W       = 10,
    parameter int DATA_W       = 32,
    parameter bit DROP_ON_FULL = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic              sample_valid,
    input  logic [DATA_W-1:0] sample_data,
    output logic              sample_ready,
    input  logic              flush,
    output logic [ADDR_W-1:0] bram_addr,
    output logic [DATA_W-1:0] bram_data,
    output logic              bram_en,
    output logic              rd_req,
    output logic              rd_half,
    output logic [ADDR_W-1:0] rd_len,
    input  logic              rd_ack,
    output logic [15:0]       drop_cnt,
    output logic              busy
);

    localparam int         c_PTR_W     = ADDR_W - 1;
    localparam logic [1:0] c_IDLE      = 2'd0;
    localparam logic [1:0] c_FILL      = 2'd1;
    localparam logic [1:0] c_WAIT_FREE = 2'd2;

    logic [1:0]          r_state;
    logic [1:0]          w_state_nxt;
    logic                r_wr_half;
    logic [c_PTR_W-1:0]  r_wr_ptr;
    logic [1:0]          r_full;
    logic [ADDR_W-1:0]   r_len [2];
    logic                r_rd_half;
    logic                r_rel_gap;
    logic                r_bram_en;
    logic [ADDR_W-1:0]   r_bram_addr;
    logic [DATA_W-1:0]   r_bram_data;
    logic [15:0]         r_drop_cnt;

    logic                w_ready;
    logic                w_wr;
    logic                w_drop;
    logic                w_rd_req;
    logic                w_rel;
    logic                w_close;
    logic [ADDR_W-1:0]   w_close_len;
    logic                w_other;
    logic                w_next_free;

    assign w_ready  = enable & ((r_state == c_FILL) |
                                ((r_state == c_WAIT_FREE) & DROP_ON_FULL));
    assign w_wr     = sample_valid & w_ready & (r_state == c_FILL);
    assign w_drop   = sample_valid & w_ready & (r_state == c_WAIT_FREE);

    // The request is masked for one cycle after every release so the reader
    // always sees a clean edge between consecutive halves.
    assign w_rd_req = r_full[r_rd_half] & ~r_rel_gap;
    assign w_rel    = rd_ack & w_rd_req;

    assign w_close     = (w_wr & (r_wr_ptr == '1)) |
                         (flush & (r_state == c_FILL) & ((r_wr_ptr != '0) | w_wr));
    assign w_close_len = {1'b0, r_wr_ptr} + {{(ADDR_W-1){1'b0}}, w_wr};

    // A same-cycle release of the other half counts as free.
    assign w_other     = ~r_wr_half;
    assign w_next_free = ~r_full[w_other] | (w_rel & (r_rd_half == w_other));

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE: begin
                if (enable && !r_full[r_wr_half]) w_state_nxt = c_FILL;
            end
            c_FILL: begin
                if (!enable)                        w_state_nxt = c_IDLE;
                else if (w_close && !w_next_free)   w_state_nxt = c_WAIT_FREE;
            end
            c_WAIT_FREE: begin
                if (!enable)                        w_state_nxt = c_IDLE;
                else if (!r_full[r_wr_half])        w_state_nxt = c_FILL;
            end
            default: w_state_nxt = c_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= c_IDLE;
            r_wr_half   <= 1'b0;
            r_wr_ptr    <= '0;
            r_full      <= 2'b00;
            r_len[0]    <= '0;
            r_len[1]    <= '0;
            r_rd_half   <= 1'b0;
            r_rel_gap   <= 1'b0;
            r_bram_en   <= 1'b0;
            r_bram_addr <= '0;
            r_bram_data <= '0;
            r_drop_cnt  <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_rel_gap <= w_rel;
            r_bram_en <= w_wr;

            if (w_rel) begin
                r_full[r_rd_half] <= 1'b0;
                r_rd_half         <= ~r_rd_half;
            end

            if (w_close) begin
                r_full[r_wr_half] <= 1'b1;
                r_len[r_wr_half]  <= w_close_len;
                r_wr_half         <= ~r_wr_half;
                r_wr_ptr          <= '0;
            end else if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + {{(c_PTR_W-1){1'b0}}, 1'b1};
            end

            if (w_wr) begin
                r_bram_addr <= {r_wr_half, r_wr_ptr};
                r_bram_data <= sample_data;
            end

            if (w_drop && (r_drop_cnt != 16'hFFFF)) begin
                r_drop_cnt <= r_drop_cnt + 16'd1;
            end
        end
    end

    assign sample_ready = w_ready;
    assign bram_en      = r_bram_en;
    assign bram_addr    = r_bram_addr;
    assign bram_data    = r_bram_data;
    assign rd_req       = w_rd_req;
    assign rd_half      = r_rd_half;
    assign rd_len       = r_len[r_rd_half];
    assign drop_cnt     = r_drop_cnt;
    assign busy         = (r_wr_ptr != '0) | (|r_full);

endmodule

`default_nettype wire

// File: tb/tb_ah_pl2ddr_buf_ctrl.sv
// ============================================================================
// tb_ah_pl2ddr_buf_ctrl : directed vector bench for ah_pl2ddr_buf_ctrl
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_ah_pl2ddr_buf_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic        sample_valid = 1'b0;
    logic [31:0] sample_data = '0;
    logic        flush = 1'b0;
    logic        rd_ack = 1'b0;

    logic        ready1, bram_en1, rd_req1, rd_half1, busy1;
    logic [9:0]  bram_addr1, rd_len1;
    logic [31:0] bram_data1;
    logic [15:0] drop_cnt1;

    logic        ready0, bram_en0, rd_req0, rd_half0, busy0;
    logic [9:0]  bram_addr0, rd_len0;
    logic [31:0] bram_data0;
    logic [15:0] drop_cnt0;

    ah_pl2ddr_buf_ctrl #(.ADDR_W(10), .DATA_W(32), .DROP_ON_FULL(1'b1)) u_dut_drop (
        .clk(clk), .rst_n(rst_n), .enable(enable),
        .sample_valid(sample_valid), .sample_data(sample_data), .sample_ready(ready1),
        .flush(flush), .bram_addr(bram_addr1), .bram_data(bram_data1), .bram_en(bram_en1),
        .rd_req(rd_req1), .rd_half(rd_half1), .rd_len(rd_len1), .rd_ack(rd_ack),
        .drop_cnt(drop_cnt1), .busy(busy1)
    );

    ah_pl2ddr_buf_ctrl #(.ADDR_W(10), .DATA_W(32), .DROP_ON_FULL(1'b0)) u_dut_stall (
        .clk(clk), .rst_n(rst_n), .enable(enable),
        .sample_valid(sample_valid), .sample_data(sample_data), .sample_ready(ready0),
        .flush(flush), .bram_addr(bram_addr0), .bram_data(bram_data0), .bram_en(bram_en0),
        .rd_req(rd_req0), .rd_half(rd_half0), .rd_len(rd_len0), .rd_ack(rd_ack),
        .drop_cnt(drop_cnt0), .busy(busy0)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic        en;
        logic        valid;
        logic [31:0] data;
        logic        fl;
        logic        ack;
        logic        x_ready;
        logic        x_en;
        logic [9:0]  x_addr;
        logic [31:0] x_data;
        logic        x_req;
        logic        x_half;
        logic [9:0]  x_len;
        logic        x_busy;
    } vec_t;

    vec_t vt [14];

    function automatic vec_t mk(input logic en, input logic valid, input logic [31:0] data,
                                input logic fl, input logic ack, input logic x_ready,
                                input logic x_en, input logic [9:0] x_addr,
                                input logic [31:0] x_data, input logic x_req,
                                input logic x_half, input logic [9:0] x_len,
                                input logic x_busy);
        vec_t v;
        v.en = en; v.valid = valid; v.data = data; v.fl = fl; v.ack = ack;
        v.x_ready = x_ready; v.x_en = x_en; v.x_addr = x_addr; v.x_data = x_data;
        v.x_req = x_req; v.x_half = x_half; v.x_len = x_len; v.x_busy = x_busy;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] d);
        sample_valid = 1'b1;
        sample_data  = d;
        tick();
    endtask

    task automatic do_reset;
        rst_n = 1'b0; enable = 1'b0; sample_valid = 1'b0; flush = 1'b0; rd_ack = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        enable = 1'b1;
        tick();
    endtask

    initial begin
        int bad;
        logic [9:0] a;

        vt[0]  = mk(0,0,32'h00,0,0, 0,0,10'h000,32'h00, 0,0,10'd0,0);
        vt[1]  = mk(1,1,32'hA0,0,0, 1,0,10'h000,32'h00, 0,0,10'd0,0);
        vt[2]  = mk(1,1,32'hA1,0,0, 1,1,10'h000,32'hA1, 0,0,10'd0,1);
        vt[3]  = mk(1,1,32'h11,0,0, 1,1,10'h001,32'h11, 0,0,10'd0,1);
        vt[4]  = mk(1,0,32'h00,1,0, 1,0,10'h001,32'h11, 1,0,10'd2,1);
        vt[5]  = mk(1,1,32'h22,0,0, 1,1,10'h200,32'h22, 1,0,10'd2,1);
        vt[6]  = mk(1,0,32'h00,0,1, 1,0,10'h200,32'h22, 0,1,10'd0,1);
        vt[7]  = mk(1,1,32'h33,1,0, 1,1,10'h201,32'h33, 1,1,10'd2,1);
        vt[8]  = mk(1,0,32'h00,1,0, 1,0,10'h201,32'h33, 1,1,10'd2,1);
        vt[9]  = mk(1,0,32'h00,0,1, 1,0,10'h201,32'h33, 0,0,10'd2,0);
        vt[10] = mk(1,0,32'h00,0,1, 1,0,10'h201,32'h33, 0,0,10'd2,0);
        vt[11] = mk(0,1,32'h66,0,0, 0,0,10'h201,32'h33, 0,0,10'd2,0);
        vt[12] = mk(1,1,32'h44,0,0, 1,0,10'h201,32'h33, 0,0,10'd2,0);
        vt[13] = mk(1,1,32'h55,0,0, 1,1,10'h000,32'h55, 0,0,10'd2,1);

        // reset values while rst_n is held low
        #2;
        chk("rst ready",    ready1,    0);
        chk("rst bram_en",  bram_en1,  0);
        chk("rst addr",     bram_addr1, 0);
        chk("rst data",     bram_data1, 0);
        chk("rst rd_req",   rd_req1,   0);
        chk("rst rd_len",   rd_len1,   0);
        chk("rst drop_cnt", drop_cnt1, 0);
        chk("rst busy",     busy1,     0);
        tick();
        tick();
        rst_n = 1'b1;

        for (int k = 0; k < 14; k++) begin
            enable = vt[k].en; sample_valid = vt[k].valid; sample_data = vt[k].data;
            flush = vt[k].fl; rd_ack = vt[k].ack;
            tick();
            chk($sformatf("v%0d ready", k),   ready1,     vt[k].x_ready);
            chk($sformatf("v%0d bram_en", k), bram_en1,   vt[k].x_en);
            chk($sformatf("v%0d addr", k),    bram_addr1, vt[k].x_addr);
            chk($sformatf("v%0d data", k),    bram_data1, vt[k].x_data);
            chk($sformatf("v%0d rd_req", k),  rd_req1,    vt[k].x_req);
            chk($sformatf("v%0d rd_half", k), rd_half1,   vt[k].x_half);
            chk($sformatf("v%0d rd_len", k),  rd_len1,    vt[k].x_len);
            chk($sformatf("v%0d drop", k),    drop_cnt1,  0);
            chk($sformatf("v%0d busy", k),    busy1,      vt[k].x_busy);
        end

        // first half fills and writing rolls into the second half without a bubble
        do_reset();
        bad = 0;
        for (int i = 0; i < 512; i++) begin
            a = i[9:0];
            push(32'(i));
            if (!(bram_en1 === 1'b1 && bram_addr1 === a && bram_data1 === 32'(i))) bad++;
        end
        chk("t1 stream writes", bad, 0);
        chk("t1 rd_req",  rd_req1,  1);
        chk("t1 rd_half", rd_half1, 0);
        chk("t1 rd_len",  rd_len1,  512);
        chk("t1 ready",   ready1,   1);
        push(32'h200);
        sample_valid = 1'b0;
        chk("t1 next en",   bram_en1,   1);
        chk("t1 next addr", bram_addr1, 10'h200);

        // both halves full: drop mode counts, stall mode deasserts ready
        do_reset();
        bad = 0;
        for (int i = 0; i < 1024; i++) begin
            a = i[9:0];
            push(32'(i));
            if (!(bram_en1 === 1'b1 && bram_addr1 === a)) bad++;
            if (!(bram_en0 === 1'b1 && bram_addr0 === a)) bad++;
        end
        chk("t2 stream writes", bad, 0);
        chk("t2 rd_req",      rd_req1,  1);
        chk("t2 rd_half",     rd_half1, 0);
        chk("t2 rd_len",      rd_len1,  512);
        chk("t2 drop ready",  ready1,   1);
        chk("t2 stall ready", ready0,   0);
        bad = 0;
        for (int k = 0; k < 5; k++) begin
            push(32'hD00 + 32'(k));
            if (bram_en1 !== 1'b0 || bram_en0 !== 1'b0) bad++;
        end
        chk("t2 no writes when full", bad, 0);
        chk("t2 drop_cnt",  drop_cnt1, 5);
        chk("t2 stall drop_cnt", drop_cnt0, 0);
        sample_valid = 1'b0;
        rd_ack = 1'b1;
        tick();
        rd_ack = 1'b0;
        chk("t2 rd_req gap",       rd_req1, 0);
        chk("t2 stall rd_req gap", rd_req0, 0);
        chk("t2 stall ready +1",   ready0,  0);
        tick();
        chk("t2 rd_req again", rd_req1,  1);
        chk("t2 rd_half 1",    rd_half1, 1);
        chk("t2 rd_len 512",   rd_len1,  512);
        chk("t2 stall ready +2", ready0, 1);
        push(32'hABC);
        sample_valid = 1'b0;
        chk("t2 drop en",    bram_en1,   1);
        chk("t2 drop addr",  bram_addr1, 0);
        chk("t2 drop data",  bram_data1, 32'hABC);
        chk("t2 stall en",   bram_en0,   1);
        chk("t2 stall addr", bram_addr0, 0);
        chk("t2 drop_cnt kept", drop_cnt1, 5);

        // partial half via flush, then a flush with nothing written
        do_reset();
        for (int i = 0; i < 37; i++) push(32'(i));
        sample_valid = 1'b0;
        flush = 1'b1;
        tick();
        chk("t3 rd_req",  rd_req1,  1);
        chk("t3 rd_len",  rd_len1,  37);
        chk("t3 rd_half", rd_half1, 0);
        tick();
        flush = 1'b0;
        chk("t3 empty flush len", rd_len1, 37);
        chk("t3 empty flush req", rd_req1, 1);
        chk("t3 empty flush ready", ready1, 1);
        push(32'h1234);
        sample_valid = 1'b0;
        chk("t3 next en",   bram_en1,   1);
        chk("t3 next addr", bram_addr1, 10'h200);
        chk("t3 len kept",  rd_len1,    37);

        // completion of half 0 coincides with release of half 1
        do_reset();
        for (int i = 0; i < 1024; i++) push(32'(i));
        sample_valid = 1'b0;
        rd_ack = 1'b1;
        tick();
        rd_ack = 1'b0;
        tick();
        chk("t4 pending half", rd_half1, 1);
        chk("t4 pending req",  rd_req1,  1);
        for (int i = 0; i < 511; i++) push(32'(i));
        sample_valid = 1'b1;
        sample_data  = 32'd511;
        rd_ack = 1'b1;
        tick();
        rd_ack = 1'b0;
        chk("t4 last en",   bram_en1,   1);
        chk("t4 last addr", bram_addr1, 10'd511);
        chk("t4 req gap",   rd_req1,    0);
        chk("t4 ready",     ready1,     1);
        chk("t4 stall ready", ready0,   1);
        push(32'h5A5);
        sample_valid = 1'b0;
        chk("t4 cont en",   bram_en1,   1);
        chk("t4 cont addr", bram_addr1, 10'h200);
        chk("t4 drop_cnt",  drop_cnt1,  0);
        chk("t4 rd_req",    rd_req1,    1);
        chk("t4 rd_half",   rd_half1,   0);
        chk("t4 rd_len",    rd_len1,    512);

        // asynchronous reset in the middle of a half
        do_reset();
        for (int i = 0; i < 300; i++) push(32'(i));
        #2;
        rst_n = 1'b0;
        #1;
        chk("t5 ready",   ready1,     0);
        chk("t5 en",      bram_en1,   0);
        chk("t5 addr",    bram_addr1, 0);
        chk("t5 data",    bram_data1, 0);
        chk("t5 busy",    busy1,      0);
        chk("t5 rd_req",  rd_req1,    0);
        sample_valid = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        chk("t5 no req after", rd_req1, 0);
        push(32'h777);
        sample_valid = 1'b0;
        chk("t5 first en",   bram_en1,   1);
        chk("t5 first addr", bram_addr1, 0);
        chk("t5 first data", bram_data1, 32'h777);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
